// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the ripple counter sequencer.
package cnt_ctrl_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_ctrl_shadow.sv
// Modulo 2^SIZE up/down register that tracks the expected ripple counter value.
module cnt_ctrl_shadow #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            up,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= up ? q + SIZE'(1) : q - SIZE'(1);
        end
    end

endmodule

// File: rtl/ripple_cnt_ctrl.sv
// Command sequencer for the JK ripple up/down counter with direction-change settle window.
// Optional shadow counter is built when CNT_CTRL_SHADOW_EN is defined.
module ripple_cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int STEP_W     = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_up,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic              busy,
    output logic              done,
    output logic              done_aborted,
    output logic [SIZE-1:0]   shadow_q
);

    state_t              state;
    state_t              state_d;
    logic [STEP_W-1:0]   steps_left;
    logic [STEP_W-1:0]   steps_d;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_d;
    logic                up_d;
    logic                aborted_d;

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_up/cmd_steps are captured on that edge.
    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_d   = state;
        steps_d   = steps_left;
        settle_d  = settle_cnt;
        up_d      = cnt_up;
        aborted_d = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    steps_d = cmd_steps;
                    if (cmd_up != cnt_up) begin
                        state_d  = SETTLE;
                        up_d     = cmd_up;
                        settle_d = SETTLE_W'(SETTLE_CYC - 1);
                    end else if (cmd_steps != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (settle_cnt == '0) begin
                    state_d = (steps_left != '0) ? RUN : DONE;
                end else begin
                    settle_d = settle_cnt - SETTLE_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    steps_d = steps_left - STEP_W'(1);
                    if (steps_left <= STEP_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            steps_left   <= '0;
            settle_cnt   <= '0;
            cnt_up       <= 1'b1;
            cnt_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_aborted <= 1'b0;
        end else begin
            state        <= state_d;
            steps_left   <= steps_d;
            settle_cnt   <= settle_d;
            cnt_up       <= up_d;
            cnt_en       <= (state_d == RUN);
            busy         <= (state_d != IDLE);
            done         <= (state_d == DONE);
            done_aborted <= aborted_d;
        end
    end

`ifdef CNT_CTRL_SHADOW_EN
    cnt_ctrl_shadow #(
        .SIZE (SIZE)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .up    (cnt_up),
        .q     (shadow_q)
    );
`else
    assign shadow_q = '0;
`endif

endmodule

// File: tb/tb_ripple_cnt_ctrl.sv
// Self-checking bench for ripple_cnt_ctrl: command table plus hand-written corner sequences.
module tb_ripple_cnt_ctrl;

    localparam int SIZE       = 4;
    localparam int STEP_W     = 8;
    localparam int SETTLE_CYC = 2;
`ifdef CNT_CTRL_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_up;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic              cnt_en;
    logic              cnt_up;
    logic              busy;
    logic              done;
    logic              done_aborted;
    logic [SIZE-1:0]   shadow_q;

    ripple_cnt_ctrl #(
        .SIZE       (SIZE),
        .STEP_W     (STEP_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_up       (cmd_up),
        .cmd_steps    (cmd_steps),
        .abort        (abort),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted),
        .shadow_q     (shadow_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [SIZE-1:0] exp_q[$];
    logic cur_up;
    logic [SIZE-1:0] model_shadow;

    typedef struct {
        logic            up;
        int              steps;
        int              abort_k;
        int              exp_done;
        logic            exp_ab;
        logic [SIZE-1:0] exp_shadow;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [SIZE-1:0] shadow_exp(input logic [SIZE-1:0] v);
        return SHADOW ? v : '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " cnt_en"}, 32'(cnt_en), 32'd0);
        check({tag, " cnt_up"}, 32'(cnt_up), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " done_aborted"}, 32'(done_aborted), 32'd0);
        check({tag, " shadow_q"}, 32'(shadow_q), 32'd0);
    endtask

    // scoreboard: pop expected shadow value whenever the DUT reports done
    task automatic score_done(input string tag);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, " unexpected done"}, 32'(done), 32'd0);
            end else begin
                check({tag, " shadow at done"}, 32'(shadow_q), 32'(shadow_exp(exp_q.pop_front())));
            end
        end
    endtask

    // driver: issue one command and check every cycle until the FSM is back in IDLE
    task automatic run_vec(input int idx, input vec_t v);
        int start;
        string tag;
        logic exp_en;
        logic dirchg;
        dirchg = (v.up != cur_up);
        start  = dirchg ? SETTLE_CYC + 1 : 1;
        exp_q.push_back(v.exp_shadow);
        cmd_valid = 1'b1;
        cmd_up    = v.up;
        cmd_steps = STEP_W'(v.steps);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cur_up    = v.up;
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            abort = (c == v.abort_k);
            @(negedge clk);
            tag    = $sformatf("v%0d c%0d", idx, c);
            exp_en = (c >= start) && (c <= start + v.steps - 1) && (c < v.exp_done);
            check({tag, " cnt_en"}, 32'(cnt_en), 32'(exp_en));
            check({tag, " cnt_up"}, 32'(cnt_up), 32'(v.up));
            check({tag, " done"}, 32'(done), 32'(c == v.exp_done));
            check({tag, " done_aborted"}, 32'(done_aborted), 32'((c == v.exp_done) && v.exp_ab));
            check({tag, " busy"}, 32'(busy), 32'(c <= v.exp_done));
            check({tag, " cmd_ready"}, 32'(cmd_ready), 32'(c > v.exp_done));
            score_done(tag);
            if (c <= v.exp_done) begin
                @(posedge clk);
                #1;
            end
        end
        abort = 1'b0;
        model_shadow = v.exp_shadow;
    endtask

    initial begin
        // up, steps, abort_k, exp_done, exp_ab, exp_shadow
        vecs[0]  = '{1'b1,  5, 0,  6, 1'b0, 4'd5};
        vecs[1]  = '{1'b0,  3, 0,  6, 1'b0, 4'd2};
        vecs[2]  = '{1'b0,  2, 0,  3, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 20, 0, 23, 1'b0, 4'd4};
        vecs[4]  = '{1'b1,  0, 0,  1, 1'b0, 4'd4};
        vecs[5]  = '{1'b0,  0, 0,  3, 1'b0, 4'd4};
        vecs[6]  = '{1'b0,  5, 0,  6, 1'b0, 4'd15};
        vecs[7]  = '{1'b1,  1, 0,  4, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 10, 3,  4, 1'b1, 4'd3};
        vecs[9]  = '{1'b0,  4, 1,  2, 1'b1, 4'd3};
        vecs[10] = '{1'b1,  1, 0,  4, 1'b0, 4'd4};

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_up       = 1'b1;
        cmd_steps    = '0;
        abort        = 1'b0;
        cur_up       = 1'b1;
        model_shadow = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // abort while idle has no effect
        abort = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("idle abort c%0d busy", c), 32'(busy), 32'd0);
            check($sformatf("idle abort c%0d done", c), 32'(done), 32'd0);
            check($sformatf("idle abort c%0d cnt_en", c), 32'(cnt_en), 32'd0);
            check($sformatf("idle abort c%0d shadow", c), 32'(shadow_q), 32'(shadow_exp(model_shadow)));
            @(posedge clk);
            #1;
        end
        abort = 1'b0;

        // cmd_valid held high across a busy command: second accept lands on the first IDLE cycle
        exp_q.push_back(model_shadow + 4'd3);
        exp_q.push_back(model_shadow + 4'd6);
        cmd_valid = 1'b1;
        cmd_up    = 1'b1;
        cmd_steps = 8'd3;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 6) cmd_valid = 1'b0;
            @(negedge clk);
            check($sformatf("hold c%0d cmd_ready", c), 32'(cmd_ready), 32'(c == 5));
            check($sformatf("hold c%0d busy", c), 32'(busy), 32'(c != 5));
            check($sformatf("hold c%0d cnt_en", c), 32'(cnt_en),
                  32'((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            check($sformatf("hold c%0d done", c), 32'(done), 32'(c == 4 || c == 9));
            score_done($sformatf("hold c%0d", c));
            @(posedge clk);
            #1;
        end
        model_shadow = model_shadow + 4'd6;
        @(negedge clk);
        check("hold end cmd_ready", 32'(cmd_ready), 32'd1);
        check("hold end shadow", 32'(shadow_q), 32'(shadow_exp(model_shadow)));
        @(posedge clk);
        #1;

        // reset in the middle of an up/8 run
        cmd_valid = 1'b1;
        cmd_up    = 1'b1;
        cmd_steps = 8'd8;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrun cnt_en before reset", 32'(cnt_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_shadow = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("post reset c%0d done", c), 32'(done), 32'd0);
            check($sformatf("post reset c%0d cmd_ready", c), 32'(cmd_ready), 32'd1);
        end
        check_reset_outputs("post reset");

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
